dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the CPU MEM stage (port C) and a debug/DMA loader (port D).
- Fixed CPU priority, with an anti-starvation override for port D.
- Sequences single-cycle writes and two-phase reads (issue, then data), and generates the CPU pipeline stall.
- Sits between the EX/MEM pipeline register and data_mem; the debug port connects to the test/loader logic.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_starve_counter.sv | 37 +++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant encoding and
// the width of the starvation counter.
package dmem_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_CPU_RD = 2'd1,
        ARB_DBG_RD = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2
    } arb_gnt_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of arbitration cycles the debug port has lost in a row;
// at_limit tells the arbiter to let the debug port win the next contest.
module arb_starve_counter
    import dmem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic                at_limit
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Clear wins over increment; the count never moves past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the
// debug/DMA loader, sequencing writes and two-phase reads and stalling the CPU.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  dbg_rvalid_q, dbg_rvalid_d;

    arb_gnt_e gnt;
    logic     idle;
    logic     at_limit;
    logic     starve_inc;
    logic     starve_clr;

    assign idle = (state_q == ARB_IDLE);

    // Gating with reset keeps every strobe quiet while reset is held, even
    // though the state register already sits in ARB_IDLE.
    always_comb begin
        gnt = GNT_NONE;
        if (reset && idle) begin
            if (cpu_req && !(dbg_valid && at_limit)) begin
                gnt = GNT_CPU;
            end else if (dbg_valid) begin
                gnt = GNT_DBG;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            GNT_DBG: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = ARB_IDLE;
        hold_d       = hold_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = 1'b0;
        cpu_stall    = cpu_req;
        cpu_rdata    = hold_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt == GNT_CPU) begin
                    cpu_stall = !cpu_we;
                    state_d   = cpu_we ? ARB_IDLE : ARB_CPU_RD;
                end else if (gnt == GNT_DBG && !dbg_we) begin
                    state_d = ARB_DBG_RD;
                end
            end
            ARB_CPU_RD: begin
                cpu_stall = 1'b0;
                cpu_rdata = mem_rdata;
                hold_d    = mem_rdata;
            end
            ARB_DBG_RD: begin
                dbg_rdata_d  = mem_rdata;
                dbg_rvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_ready  = (gnt == GNT_DBG);
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    // The starvation count only moves in arbitration cycles.
    assign starve_inc = idle && dbg_valid && (gnt != GNT_DBG);
    assign starve_clr = idle && (!dbg_valid || (gnt == GNT_DBG));

    arb_starve_counter u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (LIMIT),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            hold_q       <= '0;
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a transaction-level
// model of who owns the memory and what each read must return.
module tb_dmem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_valid, dbg_ready, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory seen by the DUT, preloaded on the first edge.
    logic [DW-1:0] mem [256];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i * 3);
            mem[8'h20] <= 16'h1234;
            mem_init   <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: pend 0 = free, 1 = CPU load data owed, 2 = debug load data owed.
    logic [DW-1:0] ref_mem [256];
    int            pend = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_drd = '0;
    logic          m_rv = 1'b0;
    int            m_starve = 0;
    logic          last_stall = 1'b0;
    logic          last_ready = 1'b0;

    logic          cap_stall, cap_ready, cap_en, cap_we, cap_rvalid;
    logic [DW-1:0] cap_crd, cap_drd;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = 0; m_hold = '0; m_drd = '0; m_rv = 1'b0; m_starve = 0;
        last_stall = 1'b0; last_ready = 1'b0;
    endtask

    // One clock cycle: predict, compare at the falling edge, then advance the model.
    task automatic run_cycle(input string tag);
        logic g_cpu, g_dbg, e_stall, e_en;
        logic [DW-1:0] e_crd;
        g_cpu   = (pend == 0) && cpu_req && !(dbg_valid && (m_starve == STARVE_LIMIT));
        g_dbg   = (pend == 0) && dbg_valid && !g_cpu;
        e_stall = (pend == 1) ? 1'b0 : (cpu_req && !(g_cpu && cpu_we));
        e_en    = g_cpu || g_dbg;
        e_crd   = (pend == 1) ? pend_data : m_hold;
        @(negedge clk);
        cap_stall = cpu_stall; cap_ready = dbg_ready; cap_en = mem_en; cap_we = mem_we;
        cap_rvalid = dbg_rvalid; cap_crd = cpu_rdata; cap_drd = dbg_rdata;
        check_output($sformatf("%s.stall", tag), cpu_stall, e_stall);
        check_output($sformatf("%s.ready", tag), dbg_ready, g_dbg);
        check_output($sformatf("%s.mem_en", tag), mem_en, e_en);
        check_output($sformatf("%s.cpu_rdata", tag), cpu_rdata, e_crd);
        check_output($sformatf("%s.rvalid", tag), dbg_rvalid, m_rv);
        check_output($sformatf("%s.dbg_rdata", tag), dbg_rdata, m_drd);
        if (e_en) begin
            check_output($sformatf("%s.mem_we", tag), mem_we, g_cpu ? cpu_we : dbg_we);
            check_output($sformatf("%s.mem_addr", tag), mem_addr, g_cpu ? cpu_addr : dbg_addr);
            if (mem_we) check_output($sformatf("%s.mem_wdata", tag), mem_wdata, g_cpu ? cpu_wdata : dbg_wdata);
        end
        last_stall = e_stall;
        last_ready = g_dbg;
        if (pend == 1) m_hold = pend_data;
        m_rv = (pend == 2);
        if (pend == 2) m_drd = pend_data;
        if (pend == 0) begin
            if (!dbg_valid || g_dbg) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end
        pend = 0;
        if (g_cpu) begin
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else begin pend = 1; pend_data = ref_mem[cpu_addr]; end
        end
        if (g_dbg) begin
            if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
            else begin pend = 2; pend_data = ref_mem[dbg_addr]; end
        end
        @(posedge clk);
        #1;
    endtask

    // Random requests that respect the hold-while-stalled and hold-until-ready rules.
    task automatic apply_stimulus();
        if (!last_stall) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom_range(0, 7));
            cpu_wdata = DW'($urandom);
        end
        if (!dbg_valid || last_ready) begin
            dbg_valid = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = AW'($urandom_range(0, 7));
            dbg_wdata = DW'($urandom);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_valid = v; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic quiesce();
        for (int i = 0; i < 6; i++) begin
            if (!last_stall) cpu_req = 1'b0;
            if (!dbg_valid || last_ready) dbg_valid = 1'b0;
            run_cycle("quiesce");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 3);
        ref_mem[8'h20] = 16'h1234;
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dbg(1'b0, 1'b0, '0, '0);
        #3;
        check_output("rst.mem_en", mem_en, 0);
        check_output("rst.stall", cpu_stall, 0);
        check_output("rst.ready", dbg_ready, 0);
        check_output("rst.rvalid", dbg_rvalid, 0);
        check_output("rst.cpu_rdata", cpu_rdata, 0);
        check_output("rst.dbg_rdata", dbg_rdata, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_reset();

        set_cpu(1'b1, 1'b1, 8'h10, 16'hBEEF);
        run_cycle("store");
        check_output("store.mem_we", cap_we, 1);
        check_output("store.stall", cap_stall, 0);
        set_cpu(1'b0, 1'b0, '0, '0);
        run_cycle("gap");
        set_cpu(1'b1, 1'b0, 8'h10, '0);
        run_cycle("load_issue");
        check_output("load.stall_issue", cap_stall, 1);
        run_cycle("load_data");
        check_output("load.stall_data", cap_stall, 0);
        check_output("load.value", cap_crd, 16'hBEEF);
        set_cpu(1'b0, 1'b0, '0, '0);

        set_dbg(1'b1, 1'b0, 8'h20, '0);
        run_cycle("dbg_rd_T");
        check_output("dbgrd.ready_T", cap_ready, 1);
        set_dbg(1'b0, 1'b0, '0, '0);
        run_cycle("dbg_rd_T1");
        check_output("dbgrd.rvalid_T1", cap_rvalid, 0);
        run_cycle("dbg_rd_T2");
        check_output("dbgrd.rvalid_T2", cap_rvalid, 1);
        check_output("dbgrd.rdata_T2", cap_drd, 16'h1234);
        run_cycle("dbg_rd_T3");
        check_output("dbgrd.rvalid_T3", cap_rvalid, 0);

        set_dbg(1'b1, 1'b1, 8'h50, 16'h5A5A);
        for (int i = 0; i < 10; i++) begin
            set_cpu(1'b1, 1'b1, AW'(8'h40 + (i % 4)), DW'(i + 16'h0100));
            run_cycle("contend");
            check_output($sformatf("contend.ready%0d", i), cap_ready, (i % 5) == 4);
            check_output($sformatf("contend.stall%0d", i), cap_stall, (i % 5) == 4);
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dbg(1'b0, 1'b0, '0, '0);
        run_cycle("gap");

        set_dbg(1'b1, 1'b0, 8'h20, '0);
        run_cycle("mix_T");
        check_output("mix.ready_T", cap_ready, 1);
        set_dbg(1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b0, 8'h10, '0);
        run_cycle("mix_T1");
        check_output("mix.stall_T1", cap_stall, 1);
        check_output("mix.en_T1", cap_en, 0);
        run_cycle("mix_T2");
        check_output("mix.stall_T2", cap_stall, 1);
        check_output("mix.en_T2", cap_en, 1);
        run_cycle("mix_T3");
        check_output("mix.stall_T3", cap_stall, 0);
        check_output("mix.rdata_T3", cap_crd, 16'hBEEF);
        set_cpu(1'b0, 1'b0, '0, '0);

        set_dbg(1'b1, 1'b1, 8'h05, 16'h00AA);
        run_cycle("wr_rd_dbgwrite");
        set_dbg(1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b0, 8'h05, '0);
        run_cycle("wr_rd_issue");
        run_cycle("wr_rd_data");
        check_output("wr_rd.value", cap_crd, 16'h00AA);
        set_cpu(1'b0, 1'b0, '0, '0);
        run_cycle("gap");

        for (int i = 0; i < 400; i++) begin
            apply_stimulus();
            run_cycle($sformatf("rand%0d", i));
        end
        quiesce();

        set_cpu(1'b1, 1'b0, 8'h10, '0);
        run_cycle("rstrd_issue");
        #2;
        reset = 1'b0;
        #1;
        check_output("rstrd.mem_en", mem_en, 0);
        check_output("rstrd.mem_we", mem_we, 0);
        check_output("rstrd.mem_addr", mem_addr, 0);
        check_output("rstrd.mem_wdata", mem_wdata, 0);
        check_output("rstrd.ready", dbg_ready, 0);
        check_output("rstrd.stall", cpu_stall, 1);
        check_output("rstrd.cpu_rdata", cpu_rdata, 0);
        check_output("rstrd.rvalid", dbg_rvalid, 0);
        check_output("rstrd.dbg_rdata", dbg_rdata, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        run_cycle("rstrd_reissue");
        check_output("rstrd.reissue_en", cap_en, 1);
        check_output("rstrd.reissue_stall", cap_stall, 1);
        run_cycle("rstrd_data");
        check_output("rstrd.value", cap_crd, 16'hBEEF);
        set_cpu(1'b0, 1'b0, '0, '0);
        run_cycle("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
